rd_adr_gen: RTL and testbench

Read-side address generator for the 640-sample capture buffer. Once the write side signals a full buffer, this block reads the buffer out at the display pixel rate, one address per pixel strobe, starting at a line boundary. After the programmed number of passes it hands the buffer back to the write side with a release pulse so the trigger can re-arm. It sits between the dual-port sample RAM read port and the display timing generator.

---
 rtl/rd_adr_gen_pkg.sv | 16 +
 rtl/rd_adr_gen_if.sv | 51 +++++
 rtl/rd_ctrl.sv | 85 ++++++++
 rtl/rd_adr_gen.sv | 79 +++++++
 tb/tb_rd_adr_gen.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/rd_adr_gen_pkg.sv
// Shared definitions for the capture-buffer address generators (read and write side).
package rd_adr_gen_pkg;

  // Buffer-ownership FSM states, common to both controllers.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StRead    = 2'd2,
    StRelease = 2'd3
  } buf_state_e;

  localparam int unsigned DefDepth = 640;
  localparam int unsigned DefAw    = 10;
  localparam int unsigned PassCntW = 4;

endpackage

// File: rtl/rd_adr_gen_if.sv
// Read-side bus: buffer handshake from the write side, display timing strobes and
// the RAM read port. The freeze signal exists only when RD_FREEZE_EN is defined.
interface rd_adr_gen_if
  import rd_adr_gen_pkg::*;
#(
  parameter int unsigned AW = DefAw
);

  logic          buf_full;
  logic          line_start;
  logic          pix_en;
`ifdef RD_FREEZE_EN
  logic          freeze;
`endif
  logic [AW-1:0] rd_addr;
  logic          rden;
  logic          rd_valid;
  logic          buf_release;
  logic          busy;

  // The address generator side.
  modport master (
`ifdef RD_FREEZE_EN
    input  freeze,
`endif
    input  buf_full,
    input  line_start,
    input  pix_en,
    output rd_addr,
    output rden,
    output rd_valid,
    output buf_release,
    output busy
  );

  // The environment side (write side, display timing, RAM).
  modport slave (
`ifdef RD_FREEZE_EN
    output freeze,
`endif
    output buf_full,
    output line_start,
    output pix_en,
    input  rd_addr,
    input  rden,
    input  rd_valid,
    input  buf_release,
    input  busy
  );

endinterface

// File: rtl/rd_ctrl.sv
// Read-side buffer controller: ownership FSM and pass counter, mirroring the write-side
// controller. With RD_FREEZE_EN defined, freeze_i holds the buffer in RELEASE.
module rd_ctrl
  import rd_adr_gen_pkg::*;
#(
  parameter int unsigned NUM_PASSES = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
`ifdef RD_FREEZE_EN
  input  logic       freeze_i,
`endif
  input  logic       buf_full_i,
  input  logic       line_start_i,
  input  logic       pix_en_i,
  input  logic       addr_last_i,
  output buf_state_e state_o,
  output logic       rden_o,
  output logic       buf_release_o,
  output logic       busy_o
);

  localparam logic [PassCntW-1:0] NumPassesW = PassCntW'(NUM_PASSES);

  buf_state_e          state_q, state_d;
  logic [PassCntW-1:0] pass_q, pass_d;
  logic [PassCntW-1:0] pass_inc;

  // Saturating increment so the counter never wraps past the programmed pass count.
  assign pass_inc = (pass_q >= NumPassesW) ? pass_q : pass_q + PassCntW'(1);

  // State and pass counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and Moore/Mealy outputs; rden follows pix_en only while reading.
  always_comb begin
    state_d       = state_q;
    pass_d        = pass_q;
    rden_o        = 1'b0;
    buf_release_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (buf_full_i) begin
          state_d = StArmed;
          pass_d  = '0;
        end
      end
      StArmed: begin
        // A coincident pix_en is not a read: reading starts the next cycle.
        if (line_start_i) state_d = StRead;
      end
      StRead: begin
        rden_o = pix_en_i;
        if (pix_en_i && addr_last_i) begin
          pass_d  = pass_inc;
          state_d = (pass_inc < NumPassesW) ? StArmed : StRelease;
        end
      end
      StRelease: begin
`ifdef RD_FREEZE_EN
        if (!freeze_i) begin
          buf_release_o = 1'b1;
          state_d       = StIdle;
        end
`else
        buf_release_o = 1'b1;
        state_d       = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  assign state_o = state_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: rtl/rd_adr_gen.sv
// Read-side address generator for the capture buffer. Reads DEPTH entries per pass at the
// pixel strobe rate, NUM_PASSES times, then returns the buffer to the write side.
// Optional feature: define RD_FREEZE_EN to add the freeze input that holds the buffer.
module rd_adr_gen
  import rd_adr_gen_pkg::*;
#(
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned AW         = DefAw,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned NUM_PASSES = 1
) (
  input logic          clk,
  input logic          rst,
  rd_adr_gen_if.master bus
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  buf_state_e        state;
  logic              rden;
  logic              addr_last;
  logic [AW-1:0]     addr_q, addr_d;
  logic [RD_LAT-1:0] valid_q, valid_d;

  rd_ctrl #(
    .NUM_PASSES(NUM_PASSES)
  ) u_rd_ctrl (
    .clk_i        (clk),
    .rst_ni       (rst),
`ifdef RD_FREEZE_EN
    .freeze_i     (bus.freeze),
`endif
    .buf_full_i   (bus.buf_full),
    .line_start_i (bus.line_start),
    .pix_en_i     (bus.pix_en),
    .addr_last_i  (addr_last),
    .state_o      (state),
    .rden_o       (rden),
    .buf_release_o(bus.buf_release),
    .busy_o       (bus.busy)
  );

  assign addr_last = (addr_q == LastAddr);

  // Address counter: parked at 0 while armed, steps on every read, wraps at pass end.
  always_comb begin
    addr_d = addr_q;
    if (state == StArmed) begin
      addr_d = '0;
    end else if (rden) begin
      addr_d = addr_last ? '0 : addr_q + AW'(1);
    end
  end

  // Read-data valid pipeline, advancing every cycle regardless of state.
  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = rden;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      valid_d[i] = valid_q[i-1];
    end
  end

  // Address and valid-pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.rd_addr  = addr_q;
  assign bus.rden     = rden;
  assign bus.rd_valid = valid_q[RD_LAT-1];

endmodule

// File: tb/tb_rd_adr_gen.sv
// Scoreboard bench for rd_adr_gen with two passes and a two-cycle read latency.
// Freeze scenarios are included when RD_FREEZE_EN is defined.
module tb_rd_adr_gen;

  localparam int unsigned Depth     = 640;
  localparam int unsigned Aw        = 10;
  localparam int unsigned RdLat     = 2;
  localparam int unsigned NumPasses = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  int exp_addr[$];
  int exp_valid[$];
  int exp_rel[$];

  rd_adr_gen_if #(.AW(Aw)) bus ();

  rd_adr_gen #(
    .DEPTH     (Depth),
    .AW        (Aw),
    .RD_LAT    (RdLat),
    .NUM_PASSES(NumPasses)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_sb();
    exp_addr.delete();
    exp_valid.delete();
    exp_rel.delete();
  endtask

  // Scoreboard: every read, valid and release the DUT produces must match a pushed entry.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.rden) begin
        check_eq("rden_on_strobe", 32'(bus.pix_en), 1);
        if (exp_addr.size() == 0) check_eq("rden_unexpected", 32'(bus.rden), 0);
        else check_eq("rd_addr", 32'(bus.rd_addr), exp_addr.pop_front());
      end
      if (bus.rd_valid) begin
        if (exp_valid.size() == 0) check_eq("rd_valid_unexpected", 32'(bus.rd_valid), 0);
        else check_eq("rd_valid_cycle", cyc, exp_valid.pop_front());
      end
      if (bus.buf_release) begin
        if (exp_rel.size() == 0) check_eq("buf_release_unexpected", 32'(bus.buf_release), 0);
        else check_eq("buf_release_cycle", cyc, exp_rel.pop_front());
      end
    end
  end

  task automatic start_buffer();
    bus.buf_full = 1'b1;
    tick();
    bus.buf_full = 1'b0;
    @(negedge clk);
    check_eq("busy_after_full", 32'(bus.busy), 1);
    tick();
  endtask

  // One pass from ARMED: gap cycles (pix_en high, no reads allowed), line_start, then
  // strobes every `period` cycles until Depth reads have been issued.
  task automatic sweep(input int period, input bit coincide, input bit last, input bit poke,
                       input int gap, input int hold);
    int n = 0;
    int k = 0;
`ifdef RD_FREEZE_EN
    if (last && hold > 0) bus.freeze = 1'b1;
`endif
    for (int i = 0; i < gap; i++) begin
      bus.pix_en = 1'b1;
      tick();
    end
    bus.line_start = 1'b1;
    bus.pix_en     = coincide;
    tick();
    bus.line_start = 1'b0;
    while (n < int'(Depth)) begin
      bus.pix_en   = (k % period == 0);
      bus.buf_full = poke && (k == 37);
      bus.line_start = (k % 97 == 50);
      if (bus.pix_en) begin
        exp_addr.push_back(n);
        exp_valid.push_back(cyc + int'(RdLat));
        n++;
      end
      tick();
      k++;
    end
    bus.pix_en     = 1'b0;
    bus.buf_full   = 1'b0;
    bus.line_start = 1'b0;
    if (last) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_eq("busy_frozen", 32'(bus.busy), 1);
        tick();
      end
`ifdef RD_FREEZE_EN
      bus.freeze = 1'b0;
`endif
      exp_rel.push_back(cyc);
      @(negedge clk);
      check_eq("busy_in_release", 32'(bus.busy), 1);
      tick();
      @(negedge clk);
      check_eq("busy_after_release", 32'(bus.busy), 0);
      tick();
    end else begin
      @(negedge clk);
      check_eq("busy_between_passes", 32'(bus.busy), 1);
      tick();
    end
  endtask

  initial begin
    bus.buf_full   = 1'b0;
    bus.line_start = 1'b0;
    bus.pix_en     = 1'b0;
`ifdef RD_FREEZE_EN
    bus.freeze     = 1'b0;
`endif
    @(negedge clk);
    check_eq("reset_rd_addr", 32'(bus.rd_addr), 0);
    check_eq("reset_rden", 32'(bus.rden), 0);
    check_eq("reset_rd_valid", 32'(bus.rd_valid), 0);
    check_eq("reset_buf_release", 32'(bus.buf_release), 0);
    check_eq("reset_busy", 32'(bus.busy), 0);
    tick();
    rst = 1'b1;
    tick();

    // Continuous strobes, line_start shortly after buf_full.
    start_buffer();
    sweep(1, 1'b0, 1'b0, 1'b0, 2, 0);
    sweep(1, 1'b0, 1'b1, 1'b0, 2, 0);

    // Strobe every 4th cycle.
    start_buffer();
    sweep(4, 1'b0, 1'b0, 1'b0, 2, 0);
    sweep(4, 1'b0, 1'b1, 1'b0, 2, 0);

    // Passes started by line_start pulses 800 cycles apart.
    start_buffer();
    sweep(1, 1'b0, 1'b0, 1'b0, 158, 0);
    sweep(1, 1'b0, 1'b1, 1'b0, 158, 0);

    // line_start coincident with pix_en; buf_full pulsed mid-read.
    start_buffer();
    sweep(1, 1'b1, 1'b0, 1'b1, 2, 0);
    sweep(3, 1'b1, 1'b1, 1'b1, 2, 0);

`ifdef RD_FREEZE_EN
    start_buffer();
    sweep(1, 1'b0, 1'b0, 1'b0, 2, 0);
    sweep(1, 1'b0, 1'b1, 1'b0, 2, 50);
`endif

    // Reset asserted mid-read at address 300.
    start_buffer();
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      bus.pix_en = 1'b1;
      exp_addr.push_back(n);
      exp_valid.push_back(cyc + int'(RdLat));
      tick();
    end
    check_eq("rd_addr_before_reset", 32'(bus.rd_addr), 300);
    rst = 1'b0;
    flush_sb();
    #1;
    check_eq("midreset_rd_addr", 32'(bus.rd_addr), 0);
    check_eq("midreset_rden", 32'(bus.rden), 0);
    check_eq("midreset_rd_valid", 32'(bus.rd_valid), 0);
    check_eq("midreset_buf_release", 32'(bus.buf_release), 0);
    check_eq("midreset_busy", 32'(bus.busy), 0);
    tick();
    tick();
    rst = 1'b1;
    // No buf_full yet: strobes and line_starts must not produce any read.
    for (int i = 0; i < 30; i++) begin
      bus.pix_en     = 1'b1;
      bus.line_start = (i % 5 == 0);
      tick();
    end
    bus.pix_en     = 1'b0;
    bus.line_start = 1'b0;
    @(negedge clk);
    check_eq("idle_after_reset", 32'(bus.busy), 0);
    tick();

    // Normal operation resumes after a fresh buf_full.
    start_buffer();
    sweep(2, 1'b0, 1'b0, 1'b0, 5, 0);
    sweep(1, 1'b1, 1'b1, 1'b0, 5, 0);

    repeat (4) tick();
    check_eq("addr_queue_drained", exp_addr.size(), 0);
    check_eq("valid_queue_drained", exp_valid.size(), 0);
    check_eq("release_queue_drained", exp_rel.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
